washing_machine: RTL and testbench



---
 rtl/washing_machine.sv | 139 +++++++++++++
 tb/tb_washing_machine.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/washing_machine.sv
// Washing-machine sequencer: a Moore FSM stepping through fill, wash, drain,
// rinse and spin phases of fixed cycle counts, then waiting in DONE for start
// to drop. It supports pause and door-open holds and a power-cut abort.
//
// Parameters: FILL_CYCLES, WASH_CYCLES, DRAIN_CYCLES, RINSE_CYCLES, SPIN_CYCLES
//             (phase durations in clock cycles, 1..255).
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   start       level; begins a cycle from IDLE, DONE waits for it to drop
//   pause       level; freezes sequencing and actuators while high
//   door_open   level; interlock, blocks start and freezes sequencing
//   power_cut   level; synchronous abort to IDLE
//   state       registered state code
//   motor, valve, drain_pump, spin_motor   actuator enables
module washing_machine #(
  parameter int unsigned FILL_CYCLES  = 5,
  parameter int unsigned WASH_CYCLES  = 10,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned RINSE_CYCLES = 7,
  parameter int unsigned SPIN_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       door_open,
  input  logic       power_cut,
  output logic [2:0] state,
  output logic       motor,
  output logic       valve,
  output logic       drain_pump,
  output logic       spin_motor
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] FILL_WATER = 3'd1;
  localparam logic [2:0] WASH       = 3'd2;
  localparam logic [2:0] DRAIN      = 3'd3;
  localparam logic [2:0] RINSE      = 3'd4;
  localparam logic [2:0] SPIN       = 3'd5;
  localparam logic [2:0] DONE       = 3'd6;

  typedef enum logic [2:0] {
    StIdle  = IDLE,
    StFill  = FILL_WATER,
    StWash  = WASH,
    StDrain = DRAIN,
    StRinse = RINSE,
    StSpin  = SPIN,
    StDone  = DONE,
    StBad   = 3'd7
  } state_e;

  state_e     state_q, state_d, next_phase;
  logic [7:0] cnt_q, cnt_d, last_cnt;
  logic       hold;

  assign hold  = pause | door_open;
  assign state = state_q;

  // Successor phase and terminal count of the current timed phase.
  always_comb begin
    next_phase = StIdle;
    last_cnt   = '0;
    case (state_q)
      StFill:  begin next_phase = StWash;  last_cnt = 8'(FILL_CYCLES - 1);  end
      StWash:  begin next_phase = StDrain; last_cnt = 8'(WASH_CYCLES - 1);  end
      StDrain: begin next_phase = StRinse; last_cnt = 8'(DRAIN_CYCLES - 1); end
      StRinse: begin next_phase = StSpin;  last_cnt = 8'(RINSE_CYCLES - 1); end
      StSpin:  begin next_phase = StDone;  last_cnt = 8'(SPIN_CYCLES - 1);  end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (power_cut) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (start && !door_open) state_d = StFill;
        end
        StFill, StWash, StDrain, StRinse, StSpin: begin
          // Hold keeps both state and count so the phase resumes where it left off.
          if (!hold) begin
            if (cnt_q == last_cnt) begin
              state_d = next_phase;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        StDone: begin
          cnt_d = '0;
          if (!start) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode, gated combinationally so a hold kills actuators immediately.
  always_comb begin
    motor      = 1'b0;
    valve      = 1'b0;
    drain_pump = 1'b0;
    spin_motor = 1'b0;
    if (!hold) begin
      case (state_q)
        StFill:  valve = 1'b1;
        StWash:  motor = 1'b1;
        StDrain: drain_pump = 1'b1;
        StRinse: begin valve = 1'b1; motor = 1'b1; end
        StSpin:  begin spin_motor = 1'b1; drain_pump = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_washing_machine.sv
// Self-checking bench for washing_machine: directed scenarios plus a random
// run, all compared against a phase/remaining-time model of the controller.
module tb_washing_machine;

  localparam int DUR_FILL  = 5;
  localparam int DUR_WASH  = 10;
  localparam int DUR_DRAIN = 5;
  localparam int DUR_RINSE = 7;
  localparam int DUR_SPIN  = 8;

  logic       clk = 1'b0;
  logic       reset, start, pause, door_open, power_cut;
  logic [2:0] state;
  logic       motor, valve, drain_pump, spin_motor;
  logic [3:0] act;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase index (equals the state code) and cycles left in the phase.
  int m_phase = 0;
  int m_rem   = 0;
  int dur [7] = '{0, DUR_FILL, DUR_WASH, DUR_DRAIN, DUR_RINSE, DUR_SPIN, 0};
  // {motor, valve, drain_pump, spin_motor} per phase
  logic [3:0] act_tab [7] = '{4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b0000};

  washing_machine #(
    .FILL_CYCLES (DUR_FILL),
    .WASH_CYCLES (DUR_WASH),
    .DRAIN_CYCLES(DUR_DRAIN),
    .RINSE_CYCLES(DUR_RINSE),
    .SPIN_CYCLES (DUR_SPIN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .door_open (door_open),
    .power_cut (power_cut),
    .state     (state),
    .motor     (motor),
    .valve     (valve),
    .drain_pump(drain_pump),
    .spin_motor(spin_motor)
  );

  always #5 clk = ~clk;
  assign act = {motor, valve, drain_pump, spin_motor};

  function automatic logic [3:0] exp_act();
    if (pause || door_open) return 4'b0000;
    return act_tab[m_phase];
  endfunction

  function automatic int exp_cnt();
    return dur[m_phase] - m_rem;
  endfunction

  task automatic drive(input logic r, input logic s, input logic p, input logic d,
                       input logic pc);
    reset = r; start = s; pause = p; door_open = d; power_cut = pc;
  endtask

  // One clock edge; the model advances from the inputs sampled at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset || power_cut) begin
      m_phase = 0;
      m_rem   = 0;
    end else if (m_phase == 0) begin
      if (start && !door_open) begin
        m_phase = 1;
        m_rem   = dur[1];
      end
    end else if (m_phase == 6) begin
      if (!start) m_phase = 0;
    end else if (!(pause || door_open)) begin
      m_rem--;
      if (m_rem == 0) begin
        m_phase++;
        m_rem = dur[m_phase];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state got=%0d exp=0", state);
    end
    n_checks++;
    if (act !== 4'b0000) begin
      n_fail++; $display("FAIL reset_act got=%b exp=0000", act);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // start held from reset release through DONE; leaves the DUT in DONE.
  task automatic test_nominal();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 36; i++) begin
      tick();
      n_checks++;
      if (state !== 3'(m_phase) || act !== exp_act()) begin
        n_fail++;
        $display("FAIL nominal edge=%0d state=%0d act=%b exp_state=%0d exp_act=%b",
                 i, state, act, m_phase, exp_act());
      end
      if (i == 35) begin
        n_checks++;
        if (state !== 3'd5) begin
          n_fail++; $display("FAIL nominal_spin_last got=%0d exp=5", state);
        end
      end
      if (i == 36) begin
        n_checks++;
        if (state !== 3'd6) begin
          n_fail++; $display("FAIL nominal_done_latency got=%0d exp=6", state);
        end
      end
    end
  endtask

  task automatic test_done_exit();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (state !== 3'd6 || act !== 4'b0000) begin
        n_fail++; $display("FAIL done_hold state=%0d act=%b exp_state=6 exp_act=0000", state, act);
      end
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL done_exit got=%0d exp=0", state);
    end
  endtask

  task automatic test_pause();
    int done_at;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    pause = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd2 || dut.cnt_q !== 8'd4 || act !== 4'b0000) begin
      n_fail++;
      $display("FAIL pause_entry state=%0d cnt=%0d act=%b exp_state=2 exp_cnt=4 exp_act=0000",
               state, dut.cnt_q, act);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (state !== 3'd2 || int'(dut.cnt_q) !== 4 || act !== 4'b0000) begin
        n_fail++;
        $display("FAIL pause_frozen state=%0d cnt=%0d act=%b exp_state=2 exp_cnt=4 exp_act=0000",
                 state, dut.cnt_q, act);
      end
    end
    pause   = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      tick();
      n_checks++;
      if (state !== 3'(m_phase) || act !== exp_act()) begin
        n_fail++;
        $display("FAIL pause_resume k=%0d state=%0d act=%b exp_state=%0d exp_act=%b",
                 k, state, act, m_phase, exp_act());
      end
      if (state === 3'd6) done_at = k;
    end
    n_checks++;
    if (done_at !== 26) begin
      n_fail++; $display("FAIL pause_done_delay got=%0d exp=26", done_at);
    end
    tick();
  endtask

  task automatic test_door();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (state !== 3'd0) begin
        n_fail++; $display("FAIL door_blocks_start got=%0d exp=0", state);
      end
    end
    door_open = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 22; i++) tick();
    n_checks++;
    if (state !== 3'd4 || int'(dut.cnt_q) !== exp_cnt()) begin
      n_fail++;
      $display("FAIL door_reach_rinse state=%0d cnt=%0d exp_state=4 exp_cnt=%0d",
               state, dut.cnt_q, exp_cnt());
    end
    door_open = 1'b1;
    #1;
    n_checks++;
    if (act !== 4'b0000) begin
      n_fail++; $display("FAIL door_act_drop got=%b exp=0000", act);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (state !== 3'd4 || int'(dut.cnt_q) !== 2) begin
        n_fail++;
        $display("FAIL door_frozen state=%0d cnt=%0d exp_state=4 exp_cnt=2", state, dut.cnt_q);
      end
    end
    door_open = 1'b0;
    #1;
    n_checks++;
    if (act !== 4'b1100) begin
      n_fail++; $display("FAIL door_release_act got=%b exp=1100", act);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (state !== 3'(m_phase) || act !== exp_act()) begin
        n_fail++;
        $display("FAIL door_resume i=%0d state=%0d act=%b exp_state=%0d exp_act=%b",
                 i, state, act, m_phase, exp_act());
      end
    end
    tick();
  endtask

  task automatic test_power_cut();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 30; i++) tick();
    n_checks++;
    if (state !== 3'd5 || act !== 4'b0011) begin
      n_fail++; $display("FAIL pc_in_spin state=%0d act=%b exp_state=5 exp_act=0011", state, act);
    end
    power_cut = 1'b1;
    tick();
    n_checks++;
    if (state !== 3'd0 || act !== 4'b0000) begin
      n_fail++; $display("FAIL pc_abort state=%0d act=%b exp_state=0 exp_act=0000", state, act);
    end
    tick();
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL pc_blocks_start got=%0d exp=0", state);
    end
    power_cut = 1'b0;
    tick();
    n_checks++;
    if (state !== 3'd1 || act !== 4'b0100) begin
      n_fail++; $display("FAIL pc_restart state=%0d act=%b exp_state=1 exp_act=0100", state, act);
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL rstpri_in_wash got=%0d exp=2", state);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (state !== 3'd0 || dut.cnt_q !== 8'd0) begin
      n_fail++; $display("FAIL rstpri_idle state=%0d cnt=%0d exp_state=0 exp_cnt=0", state, dut.cnt_q);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL rstpri_restart got=%0d exp=1", state);
    end
  endtask

  task automatic test_random();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 11) == 0),
            logic'($urandom_range(0, 99) == 0));
      #1;
      n_checks++;
      if (act !== exp_act()) begin
        n_fail++;
        $display("FAIL random_act i=%0d got=%b exp=%b phase=%0d", i, act, exp_act(), m_phase);
      end
      tick();
      n_checks++;
      if (state !== 3'(m_phase) || int'(dut.cnt_q) !== (m_phase inside {[1:5]} ? exp_cnt() : 0)) begin
        n_fail++;
        $display("FAIL random_state i=%0d state=%0d cnt=%0d exp_state=%0d", i, state, dut.cnt_q,
                 m_phase);
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_nominal();
    test_done_exit();
    test_pause();
    test_door();
    test_power_cut();
    test_reset_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
